// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider.
// One quotient bit is produced per clock, MSB first, so a division with a
// nonzero divisor takes exactly `bus` cycles in RUN. A zero divisor bypasses
// RUN and reports quotient = all ones, remainder = dividend.
// The result registers keep their values until the next result is loaded.
module seq_divider #(
   parameter int bus = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [bus-1:0] dividend,
   input  logic [bus-1:0] divisor,
   output logic [bus-1:0] quotient,
   output logic [bus-1:0] remainder,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero,
   output logic           zero
);

   localparam int             CW   = $clog2(bus + 1);
   localparam logic [CW-1:0]  LAST = CW'(bus - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [bus-1:0]  dvd_q;      // dividend bits still to consume; quotient bits shift in at the LSB
   logic [bus-1:0]  dvs_q;      // divisor latched on the accepting edge
   logic [bus-1:0]  rem_q;      // partial remainder
   logic [CW-1:0]   cnt_q;      // iteration counter
   logic [bus-1:0]  quo_out_q;
   logic [bus-1:0]  rem_out_q;
   logic            busy_q;
   logic            done_q;
   logic            dbz_q;
   logic            zero_q;

   logic [bus:0]    trial_d;
   logic [bus:0]    diff_d;
   logic            qbit_d;
   logic [bus-1:0]  rem_d;
   logic [bus-1:0]  dvd_d;

   // One restoring-division step: shift in the next dividend bit, trial-subtract the divisor
   always_comb begin
      trial_d = {rem_q, dvd_q[bus-1]};
      diff_d  = trial_d - {1'b0, dvs_q};
      qbit_d  = 1'b0;
      rem_d   = trial_d[bus-1:0];
      if (diff_d[bus] == 1'b0) begin
         // Non-negative difference: keep it. The remainder stays below the
         // divisor, so the difference always fits in bus bits.
         qbit_d = 1'b1;
         rem_d  = diff_d[bus-1:0];
      end else begin
         // Negative: restore. The trial value is then below the divisor and fits in bus bits.
         qbit_d = 1'b0;
         rem_d  = trial_d[bus-1:0];
      end
      dvd_d = {dvd_q[bus-2:0], qbit_d};
   end

   // Control FSM with the datapath registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         dvd_q     <= {bus{1'b0}};
         dvs_q     <= {bus{1'b0}};
         rem_q     <= {bus{1'b0}};
         cnt_q     <= {CW{1'b0}};
         quo_out_q <= {bus{1'b0}};
         rem_out_q <= {bus{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         zero_q    <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (divisor != {bus{1'b0}}) begin
                     dvd_q   <= dividend;
                     dvs_q   <= divisor;
                     rem_q   <= {bus{1'b0}};
                     cnt_q   <= {CW{1'b0}};
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end else begin
                     // An all-ones quotient is never zero because bus >= 2.
                     quo_out_q <= {bus{1'b1}};
                     rem_out_q <= dividend;
                     dbz_q     <= 1'b1;
                     zero_q    <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= DONE;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               rem_q <= rem_d;
               dvd_q <= dvd_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  quo_out_q <= dvd_d;
                  rem_out_q <= rem_d;
                  dbz_q     <= 1'b0;
                  zero_q    <= (dvd_d == {bus{1'b0}});
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= DONE;
               end else begin
                  state_q <= RUN;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign quotient    = quo_out_q;
   assign remainder   = rem_out_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign zero        = zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks for seq_divider (bus = 8).
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = 8'd0;
   logic [7:0] divisor = 8'd0;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;
   logic       zero;

   int n_checks = 0;
   int n_fail   = 0;

   seq_divider #(.bus(8)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .quotient(quotient),
      .remainder(remainder),
      .busy(busy),
      .done(done),
      .div_by_zero(div_by_zero),
      .zero(zero)
   );

   always #5 clk = ~clk;

   // Issue one request, scramble the operand inputs afterwards and watch 14 cycles.
   // lat is the count of falling edges after the accepting edge at which done is
   // first seen (0 = never seen).
   task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic zr,
                          output int lat, output int busy_cycles, output int done_cnt);
      q = 8'hxx; r = 8'hxx; dz = 1'bx; zr = 1'bx;
      lat = 0; busy_cycles = 0; done_cnt = 0;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; dividend = ~a; divisor = 8'($urandom);
      for (int k = 1; k <= 14; k++) begin
         if (busy === 1'b1) busy_cycles++;
         if (done === 1'b1) begin
            done_cnt++;
            if (lat == 0) begin
               lat = k; q = quotient; r = remainder; dz = div_by_zero; zr = zero;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({quotient, remainder, busy, done, div_by_zero, zero} !== {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_values: got q=%h r=%h busy=%b done=%b dbz=%b zero=%b, want q=00 r=00 busy=0 done=0 dbz=0 zero=1",
                  quotient, remainder, busy, done, div_by_zero, zero);
      end
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy, done, zero} !== 3'b001) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b done=%b zero=%b, want 0 0 1", busy, done, zero);
      end
   endtask

   task automatic test_basic();
      logic [7:0] q, r; logic dz, zr; int lat, bc, dc;
      run_div(8'd200, 8'd7, q, r, dz, zr, lat, bc, dc);
      n_checks++;
      if ({q, r, dz, zr} !== {8'd28, 8'd4, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%b zero=%b, want q=28 r=4 dbz=0 zero=0", q, r, dz, zr);
      end
      n_checks++;
      if (lat !== 9 || bc !== 8 || dc !== 1) begin
         n_fail++;
         $display("FAIL basic_timing: got lat=%0d busy=%0d dones=%0d, want lat=9 busy=8 dones=1", lat, bc, dc);
      end
   endtask

   task automatic test_div_zero();
      logic [7:0] q, r; logic dz, zr; int lat, bc, dc;
      run_div(8'd5, 8'd0, q, r, dz, zr, lat, bc, dc);
      n_checks++;
      if ({q, r, dz, zr} !== {8'hFF, 8'd5, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL div_zero_result: got q=%h r=%0d dbz=%b zero=%b, want q=ff r=5 dbz=1 zero=0", q, r, dz, zr);
      end
      n_checks++;
      if (lat !== 1 || bc !== 0 || dc !== 1) begin
         n_fail++;
         $display("FAIL div_zero_timing: got lat=%0d busy=%0d dones=%0d, want lat=1 busy=0 dones=1", lat, bc, dc);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q, r; logic dz, zr; int lat, bc, dc;
      run_div(8'd7, 8'd9, q, r, dz, zr, lat, bc, dc);
      n_checks++;
      if ({q, r, dz, zr} !== {8'd0, 8'd7, 1'b0, 1'b1} || lat !== 9) begin
         n_fail++;
         $display("FAIL b2b_7_9: got q=%0d r=%0d dbz=%b zero=%b lat=%0d, want q=0 r=7 dbz=0 zero=1 lat=9", q, r, dz, zr, lat);
      end
      run_div(8'd255, 8'd1, q, r, dz, zr, lat, bc, dc);
      n_checks++;
      if ({q, r, dz, zr} !== {8'd255, 8'd0, 1'b0, 1'b0} || lat !== 9) begin
         n_fail++;
         $display("FAIL b2b_255_1: got q=%0d r=%0d dbz=%b zero=%b lat=%0d, want q=255 r=0 dbz=0 zero=0 lat=9", q, r, dz, zr, lat);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({quotient, remainder, zero, done} !== {8'd255, 8'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL result_hold: got q=%0d r=%0d zero=%b done=%b, want q=255 r=0 zero=0 done=0", quotient, remainder, zero, done);
      end
   endtask

   task automatic test_start_ignored();
      int dc = 0; int lat = 0;
      logic [7:0] q = 8'hxx; logic [7:0] r = 8'hxx;
      @(negedge clk);
      start = 1'b1; dividend = 8'd100; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 3) begin
            start = 1'b1; dividend = 8'd50; divisor = 8'd5;
         end else if (k == 4) begin
            start = 1'b0;
         end else begin
            start = start;
         end
         if (done === 1'b1) begin
            dc++;
            if (lat == 0) begin lat = k; q = quotient; r = remainder; end
         end
         @(negedge clk);
      end
      n_checks++;
      if ({q, r} !== {8'd33, 8'd1}) begin
         n_fail++;
         $display("FAIL start_ignored_result: got q=%0d r=%0d, want q=33 r=1", q, r);
      end
      n_checks++;
      if (dc !== 1 || lat !== 9) begin
         n_fail++;
         $display("FAIL start_ignored_pulses: got dones=%0d lat=%0d, want dones=1 lat=9", dc, lat);
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] q, r; logic dz, zr; int lat, bc, dc;
      int seen_done = 0;
      @(negedge clk);
      start = 1'b1; dividend = 8'd100; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_busy_before: got busy=%b, want 1", busy);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({quotient, remainder, busy, done, div_by_zero, zero} !== {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL abort_async_clear: got q=%0d r=%0d busy=%b done=%b dbz=%b zero=%b, want 0 0 0 0 0 1",
                  quotient, remainder, busy, done, div_by_zero, zero);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done === 1'b1 || busy === 1'b1) seen_done++;
         @(negedge clk);
      end
      n_checks++;
      if (seen_done !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d cycles with done/busy, want 0", seen_done);
      end
      run_div(8'd9, 8'd2, q, r, dz, zr, lat, bc, dc);
      n_checks++;
      if ({q, r, dz} !== {8'd4, 8'd1, 1'b0} || lat !== 9 || dc !== 1) begin
         n_fail++;
         $display("FAIL after_abort_9_2: got q=%0d r=%0d dbz=%b lat=%0d dones=%0d, want q=4 r=1 dbz=0 lat=9 dones=1",
                  q, r, dz, lat, dc);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] corners [6];
      logic [7:0] a, b, q, r, eq, er;
      logic dz, zr, edz;
      int lat, bc, dc, elat, ebc;
      corners = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd255};
      for (int i = 0; i < 36 + 1000; i++) begin
         if (i < 36) begin
            a = corners[i / 6];
            b = corners[i % 6];
         end else begin
            a = 8'($urandom);
            b = ($urandom_range(15, 0) == 0) ? 8'd0 : 8'($urandom);
         end
         if (b == 8'd0) begin
            eq = 8'hFF; er = a; edz = 1'b1; elat = 1; ebc = 0;
         end else begin
            eq = a / b; er = a % b; edz = 1'b0; elat = 9; ebc = 8;
         end
         run_div(a, b, q, r, dz, zr, lat, bc, dc);
         n_checks++;
         if ({q, r, dz, zr} !== {eq, er, edz, (eq == 8'd0)} || lat !== elat || bc !== ebc || dc !== 1) begin
            n_fail++;
            $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dbz=%b zero=%b lat=%0d busy=%0d dones=%0d, want q=%0d r=%0d dbz=%b zero=%b lat=%0d busy=%0d dones=1",
                     a, b, q, r, dz, zr, lat, bc, dc, eq, er, edz, (eq == 8'd0), elat, ebc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_back_to_back();
      test_start_ignored();
      test_reset_abort();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
